// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_spi_pkg;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD41 = 6'd41;
   localparam logic [5:0] CMD55 = 6'd55;

   localparam logic [7:0] R1_IDLE     = 8'h01;
   localparam logic [7:0] R1_ILLEGAL  = 8'h04;
   localparam logic [7:0] R1_CRC_ERR  = 8'h08;
   localparam logic [7:0] START_TOKEN = 8'hFE;
   localparam logic [7:0] CMD0_CRC    = 8'h95;

   typedef enum logic [2:0] {
      HUNT, CMD, NCR_WAIT, R1, NAC_WAIT, TOKEN, DATA, CRC
   } cardState_t;

endpackage

// File: rtl/spi_byte_slave.sv
// Byte-level SPI mode-0 slave: synchronises the host pins into MasterCLK,
// shifts MOSI in on SPI_CLK rise and MISO out on SPI_CLK fall.
module spi_byte_slave (
   input  logic       MasterCLK,
   input  logic       Reset,
   input  logic       SPI_CLK,
   input  logic       SPI_CS,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   input  logic [7:0] txByte,
   input  logic       txLoad,
   output logic [7:0] rxByte,
   output logic       rxValid,
   output logic       csActive
);

   logic [1:0] clkSync;
   logic [1:0] csSync;
   logic [1:0] mosiSync;
   logic       clkPrev;
   logic       spiRise;
   logic       spiFall;
   logic [2:0] bitCnt;
   logic [6:0] rxShift;
   logic [7:0] txShift;

   assign spiRise  = clkSync[1] & ~clkPrev;
   assign spiFall  = ~clkSync[1] & clkPrev;
   assign csActive = ~csSync[1];
   assign SPI_MISO = csActive ? txShift[7] : 1'b1;

   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         clkSync  <= 2'b00;
         csSync   <= 2'b11;
         mosiSync <= 2'b11;
         clkPrev  <= 1'b0;
      end else begin
         clkSync  <= {clkSync[0], SPI_CLK};
         csSync   <= {csSync[0], SPI_CS};
         mosiSync <= {mosiSync[0], SPI_MOSI};
         clkPrev  <= clkSync[1];
      end
   end

   // Each byte boundary preloads 0xFF so the card idles high unless the
   // protocol layer supplies a byte on the following cycle via txLoad.
   // The fall that closes a byte (bitCnt back at 0) must not shift.
   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         bitCnt  <= 3'd0;
         rxShift <= 7'd0;
         rxByte  <= 8'd0;
         rxValid <= 1'b0;
         txShift <= 8'hFF;
      end else begin
         rxValid <= 1'b0;
         if (!csActive) begin
            bitCnt  <= 3'd0;
            txShift <= 8'hFF;
         end else begin
            if (spiRise) begin
               rxShift <= {rxShift[5:0], mosiSync[1]};
               bitCnt  <= bitCnt + 3'd1;
               if (bitCnt == 3'd7) begin
                  rxByte  <= {rxShift, mosiSync[1]};
                  rxValid <= 1'b1;
                  txShift <= 8'hFF;
               end
            end
            if (txLoad) begin
               txShift <= txByte;
            end else if (spiFall && bitCnt != 3'd0) begin
               txShift <= {txShift[6:0], 1'b1};
            end
         end
      end
   end

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model: decodes host command frames, answers with R1 and
// serves CMD17 single-block reads from an external byte-read port.
module sd_spi_card_responder
   import sd_spi_pkg::*;
#(
   parameter int NCR        = 1,
   parameter int NAC        = 2,
   parameter int INIT_POLLS = 3
) (
   input  logic        MasterCLK,
   input  logic        Reset,
   input  logic        SPI_CLK,
   input  logic        SPI_CS,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic [31:0] ReadArg,
   output logic [8:0]  ReadIndex,
   output logic        ReadStrobe,
   input  logic [7:0]  ReadData,
   output logic        CardReady,
   output logic [5:0]  LastCmd
);

   localparam logic [7:0] NCR_B   = 8'(NCR);
   localparam logic [7:0] NAC_B   = 8'(NAC);
   localparam logic [7:0] POLLS_B = 8'(INIT_POLLS);

   cardState_t  state, nextState;
   logic [7:0]  rxByte, txByte, r1Reg, frameR1, waitCnt, pollCnt, dataBuf;
   logic        rxValid, txLoad, csActive, frameRead, readOk, idle, app, lastByte;
   logic [5:0]  cmdIndex;
   logic [31:0] argReg;
   logic [2:0]  byteCnt;
   logic [1:0]  strobeDly;

   spi_byte_slave byteSlave (
      .MasterCLK (MasterCLK),
      .Reset     (Reset),
      .SPI_CLK   (SPI_CLK),
      .SPI_CS    (SPI_CS),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO),
      .txByte    (txByte),
      .txLoad    (txLoad),
      .rxByte    (rxByte),
      .rxValid   (rxValid),
      .csActive  (csActive)
   );

   // R1 for the frame whose CRC byte is currently in rxByte.
   always_comb begin
      frameR1   = R1_ILLEGAL | {7'd0, idle};
      frameRead = 1'b0;
      if (cmdIndex == CMD0) begin
         frameR1 = (rxByte == CMD0_CRC) ? R1_IDLE : (R1_CRC_ERR | {7'd0, idle});
      end else if (cmdIndex == CMD55) begin
         frameR1 = {7'd0, idle};
      end else if (cmdIndex == CMD41 && app) begin
         frameR1 = (pollCnt < POLLS_B) ? R1_IDLE : 8'h00;
      end else if (cmdIndex == CMD17) begin
         frameR1   = idle ? (R1_ILLEGAL | R1_IDLE) : 8'h00;
         frameRead = ~idle;
      end
   end

   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) state <= HUNT;
      else        state <= nextState;
   end

   // A byte loaded at a boundary is the one clocked out during the next byte.
   always_comb begin
      nextState = state;
      txLoad    = 1'b0;
      txByte    = 8'hFF;
      if (!csActive) begin
         nextState = HUNT;
      end else if (rxValid) begin
         case (state)
            HUNT: if (rxByte[7:6] == 2'b01) nextState = CMD;
            CMD: if (byteCnt == 3'd5) begin
               txLoad = 1'b1;
               if (NCR_B == 8'd0) begin
                  txByte    = frameR1;
                  nextState = R1;
               end else begin
                  nextState = NCR_WAIT;
               end
            end
            NCR_WAIT: if (waitCnt == NCR_B) begin
               txLoad    = 1'b1;
               txByte    = r1Reg;
               nextState = R1;
            end
            R1: begin
               if (!readOk) begin
                  nextState = HUNT;
               end else if (NAC_B == 8'd0) begin
                  txLoad    = 1'b1;
                  txByte    = START_TOKEN;
                  nextState = TOKEN;
               end else begin
                  nextState = NAC_WAIT;
               end
            end
            NAC_WAIT: if (waitCnt == NAC_B) begin
               txLoad    = 1'b1;
               txByte    = START_TOKEN;
               nextState = TOKEN;
            end
            TOKEN: begin
               txLoad    = 1'b1;
               txByte    = dataBuf;
               nextState = DATA;
            end
            DATA: begin
               if (lastByte) begin
                  nextState = CRC;
               end else begin
                  txLoad = 1'b1;
                  txByte = dataBuf;
               end
            end
            CRC: if (waitCnt == 8'd1) nextState = HUNT;
            default: nextState = HUNT;
         endcase
      end
   end

   // Card flags, frame capture and the read-port prefetch, which always runs
   // one byte ahead of the byte being shifted out.
   always_ff @(posedge MasterCLK or negedge Reset) begin
      if (!Reset) begin
         cmdIndex   <= 6'd0;
         argReg     <= 32'd0;
         byteCnt    <= 3'd0;
         waitCnt    <= 8'd0;
         r1Reg      <= 8'hFF;
         readOk     <= 1'b0;
         idle       <= 1'b1;
         app        <= 1'b0;
         pollCnt    <= 8'd0;
         CardReady  <= 1'b0;
         LastCmd    <= 6'd0;
         ReadArg    <= 32'd0;
         ReadIndex  <= 9'd0;
         ReadStrobe <= 1'b0;
         strobeDly  <= 2'b00;
         dataBuf    <= 8'hFF;
         lastByte   <= 1'b0;
      end else begin
         ReadStrobe <= 1'b0;
         strobeDly  <= {strobeDly[0], ReadStrobe};
         if (strobeDly[1]) dataBuf <= ReadData;
         if (!csActive) begin
            ReadIndex <= 9'd0;
         end else if (rxValid) begin
            case (state)
               HUNT: begin
                  cmdIndex <= rxByte[5:0];
                  byteCnt  <= 3'd1;
               end
               CMD: begin
                  byteCnt <= byteCnt + 3'd1;
                  if (byteCnt != 3'd5) begin
                     argReg <= {argReg[23:0], rxByte};
                  end else begin
                     LastCmd <= cmdIndex;
                     r1Reg   <= frameR1;
                     readOk  <= frameRead;
                     waitCnt <= 8'd1;
                     app     <= 1'b0;
                     if (frameRead) ReadArg <= argReg;
                     if (cmdIndex == CMD0 && rxByte == CMD0_CRC) begin
                        idle      <= 1'b1;
                        CardReady <= 1'b0;
                        pollCnt   <= 8'd0;
                     end
                     if (cmdIndex == CMD55) app <= 1'b1;
                     if (cmdIndex == CMD41 && app) begin
                        if (pollCnt < POLLS_B) begin
                           pollCnt <= pollCnt + 8'd1;
                        end else begin
                           idle      <= 1'b0;
                           CardReady <= 1'b1;
                        end
                     end
                  end
               end
               NCR_WAIT, NAC_WAIT, CRC: waitCnt <= waitCnt + 8'd1;
               R1: waitCnt <= 8'd1;
               TOKEN: begin
                  ReadStrobe <= 1'b1;
                  ReadIndex  <= 9'd1;
               end
               DATA: begin
                  if (lastByte) begin
                     ReadIndex <= 9'd0;
                     waitCnt   <= 8'd0;
                  end else if (ReadIndex == 9'd511) begin
                     lastByte <= 1'b1;
                  end else begin
                     ReadStrobe <= 1'b1;
                     ReadIndex  <= ReadIndex + 9'd1;
                  end
               end
               default: ;
            endcase
            if (nextState == TOKEN && state != TOKEN) begin
               ReadStrobe <= 1'b1;
               ReadIndex  <= 9'd0;
               lastByte   <= 1'b0;
            end
         end
      end
   end

endmodule
